// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL sequencer.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_BIT   = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_RSVD  = 2'd3
    } scl_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        S_HOLD,
        PARK,
        B_LOW,
        B_WAIT,
        B_HIGH,
        P_LOW,
        P_WAIT,
        P_HIGH,
        R_LOW,
        R_WAIT
    } scl_state_t;

    localparam int unsigned MIN_HALF_PERIOD = 2;

    // States whose duration is set by the phase counter.
    function automatic logic is_timed(input scl_state_t s);
        return s inside {S_HOLD, B_LOW, B_HIGH, P_LOW, P_HIGH, R_LOW};
    endfunction

    // States in which the master pulls SCL low.
    function automatic logic drives_low(input scl_state_t s);
        return s inside {PARK, B_LOW, P_LOW, R_LOW};
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo-N phase counter: counts 0..rollover_val-1 while enabled and flags the
// terminal count so a phase of rollover_val cycles ends on the wrap.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    // Terminal count of the current period.
    always_comb begin
        rollover_flag = count_enable && (count_out == rollover_val - NUM_CNT_BITS'(1));
    end

    // Count register: clear has priority, wraps to zero on rollover.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + NUM_CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_scl_sequencer.sv
// Master-side SCL phase sequencer: turns START/BIT/STOP commands into timed
// SCL low/high phases, honours clock stretching and emits SDA timing strobes.
module i2c_scl_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned DIV_BITS = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic [DIV_BITS-1:0] half_period,
    input  logic                cmd_valid,
    input  scl_cmd_t            cmd,
    output logic                cmd_ready,
    input  logic                scl_in,
    output logic                scl_oe,
    output logic                shift_stb,
    output logic                sample_stb,
    output logic                sda_fall_stb,
    output logic                sda_rise_stb,
    output logic                done,
    output logic                cmd_err
);

    localparam logic [DIV_BITS-1:0] T_MIN = DIV_BITS'(MIN_HALF_PERIOD);

    scl_state_t          state;
    scl_state_t          next_state;
    logic [DIV_BITS-1:0] t_q;
    logic [DIV_BITS-1:0] cnt;
    logic                roll;
    logic                accept;
    logic                cnt_clear;
    logic                cnt_en;
    logic                entering;
    logic                oe_d, shift_d, sample_d, fall_d, rise_d, done_d, err_d;

    assign cmd_ready = enable && (state == IDLE || state == PARK);
    assign accept    = cmd_valid && cmd_ready;
    assign entering  = (next_state != state);
    assign cnt_en    = is_timed(state);
    assign cnt_clear = is_timed(next_state) && entering;

    flex_counter #(.NUM_CNT_BITS(DIV_BITS)) u_phase_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (t_q),
        .count_out     (cnt),
        .rollover_flag (roll)
    );

    // Latch the half period at command accept, clamped to the minimum.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            t_q <= T_MIN;
        end else if (accept) begin
            t_q <= (half_period < T_MIN) ? T_MIN : half_period;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept && cmd == CMD_START) next_state = S_HOLD;
            S_HOLD: if (roll) next_state = PARK;
            PARK: begin
                if (accept) begin
                    case (cmd)
                        CMD_BIT:   next_state = B_LOW;
                        CMD_STOP:  next_state = P_LOW;
                        CMD_START: next_state = R_LOW;
                        default:   next_state = PARK;
                    endcase
                end
            end
            B_LOW:  if (roll)   next_state = B_WAIT;
            B_WAIT: if (scl_in) next_state = B_HIGH;
            B_HIGH: if (roll)   next_state = PARK;
            P_LOW:  if (roll)   next_state = P_WAIT;
            P_WAIT: if (scl_in) next_state = P_HIGH;
            P_HIGH: if (roll)   next_state = IDLE;
            R_LOW:  if (roll)   next_state = R_WAIT;
            R_WAIT: if (scl_in) next_state = S_HOLD;
            default:            next_state = IDLE;
        endcase
        if (!enable) next_state = IDLE;
    end

    // Outputs are decoded one cycle ahead from next_state so that the
    // registered versions line up with the state they describe; done fires
    // when the following cycle will be the last one of a final phase.
    always_comb begin
        oe_d     = drives_low(next_state);
        shift_d  = entering && (next_state == B_LOW);
        sample_d = entering && (next_state == B_HIGH);
        fall_d   = entering && (next_state == S_HOLD);
        rise_d   = entering && (next_state == P_HIGH || next_state == R_LOW);
        done_d   = !entering && (next_state inside {S_HOLD, B_HIGH, P_HIGH})
                   && (cnt == t_q - DIV_BITS'(2));
        err_d    = 1'b0;
        if (accept) begin
            err_d = (state == IDLE) ? (cmd != CMD_START) : (cmd == CMD_RSVD);
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_oe       <= 1'b0;
            shift_stb    <= 1'b0;
            sample_stb   <= 1'b0;
            sda_fall_stb <= 1'b0;
            sda_rise_stb <= 1'b0;
            done         <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            scl_oe       <= oe_d;
            shift_stb    <= shift_d;
            sample_stb   <= sample_d;
            sda_fall_stb <= fall_d;
            sda_rise_stb <= rise_d;
            done         <= done_d;
            cmd_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_scl_sequencer.sv
// Randomised self-checking bench for i2c_scl_sequencer against a phase-list model.
module tb_i2c_scl_sequencer;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable;
    logic [9:0] half_period;
    logic       cmd_valid;
    scl_cmd_t   cmd;
    logic       cmd_ready;
    logic       scl_in;
    logic       scl_oe, shift_stb, sample_stb, sda_fall_stb, sda_rise_stb, done, cmd_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Expected per-cycle behaviour after a command accept.
    typedef struct packed {
        logic rdy, oe, shift, sample, fall, rise, done, err, sin;
    } exp_t;

    exp_t q[$];
    bit   owned = 1'b0;   // model: bus held by master (PARK) vs free (IDLE)

    i2c_scl_sequencer #(.DIV_BITS(10)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .half_period  (half_period),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_ready    (cmd_ready),
        .scl_in       (scl_in),
        .scl_oe       (scl_oe),
        .shift_stb    (shift_stb),
        .sample_stb   (sample_stb),
        .sda_fall_stb (sda_fall_stb),
        .sda_rise_stb (sda_rise_stb),
        .done         (done),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({cmd_ready, scl_oe, shift_stb, sample_stb, sda_fall_stb,
                    sda_rise_stb, done, cmd_err});
    endfunction

    function automatic logic [31:0] exp_vec(input exp_t e);
        return 32'({e.rdy, e.oe, e.shift, e.sample, e.fall, e.rise, e.done, e.err});
    endfunction

    // stb: 0 none, 1 shift, 2 sample, 3 sda fall, 4 sda rise
    task automatic add_timed(input int unsigned n, input bit oe, input int unsigned stb,
                             input bit fin);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e        = '0;
            e.oe     = oe;
            e.sin    = !oe;
            e.shift  = (i == 0) && (stb == 1);
            e.sample = (i == 0) && (stb == 2);
            e.fall   = (i == 0) && (stb == 3);
            e.rise   = (i == 0) && (stb == 4);
            e.done   = fin && (i == n - 1);
            q.push_back(e);
        end
    endtask

    // Released SCL held low by the slave for s cycles, then seen high.
    task automatic add_wait(input int unsigned s);
        exp_t e;
        for (int unsigned i = 0; i <= s; i++) begin
            e     = '0;
            e.sin = (i == s);
            q.push_back(e);
        end
    endtask

    task automatic add_err(input bit oe);
        exp_t e;
        e     = '0;
        e.rdy = 1'b1;
        e.oe  = oe;
        e.sin = !oe;
        e.err = 1'b1;
        q.push_back(e);
    endtask

    task automatic run_cmd(input scl_cmd_t c, input logic [9:0] hp, input int unsigned s);
        int unsigned t;
        bit          owned_n;
        string       tag;
        t       = (hp < 10'd2) ? 2 : 32'(hp);
        owned_n = owned;
        q.delete();
        if (!owned) begin
            if (c == CMD_START) begin
                add_timed(t, 1'b0, 3, 1'b1);
                owned_n = 1'b1;
            end else begin
                add_err(1'b0);
            end
        end else begin
            case (c)
                CMD_BIT: begin
                    add_timed(t, 1'b1, 1, 1'b0); add_wait(s); add_timed(t, 1'b0, 2, 1'b1);
                end
                CMD_STOP: begin
                    add_timed(t, 1'b1, 0, 1'b0); add_wait(s); add_timed(t, 1'b0, 4, 1'b1);
                    owned_n = 1'b0;
                end
                CMD_START: begin
                    add_timed(t, 1'b1, 4, 1'b0); add_wait(s); add_timed(t, 1'b0, 3, 1'b1);
                end
                default: add_err(1'b1);
            endcase
        end
        scl_in = !owned;
        check_val($sformatf("ready_pre_c%0d", c), 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd         = c;
        half_period = hp;
        step();
        for (int i = 0; i < q.size(); i++) begin
            half_period = 10'($urandom);
            cmd         = scl_cmd_t'($urandom_range(0, 3));
            cmd_valid   = (i + 1 < q.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
            scl_in      = q[i].sin;
            tag = $sformatf("c%0d_T%0d_cyc%0d", c, t, i + 1);
            check_val(tag, dut_vec(), exp_vec(q[i]));
            step();
        end
        owned  = owned_n;
        scl_in = !owned;
        check_val("after_cmd", dut_vec(), 32'({1'b1, owned, 6'b0}));
    endtask

    // BIT from PARK, enable dropped k cycles into the low phase.
    task automatic abort_test(input logic [9:0] hp, input int unsigned k);
        exp_t e;
        cmd_valid   = 1'b1;
        cmd         = CMD_BIT;
        half_period = hp;
        scl_in      = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int unsigned i = 0; i < k; i++) begin
            e       = '0;
            e.oe    = 1'b1;
            e.shift = (i == 0);
            check_val($sformatf("abort_low%0d", i + 1), dut_vec(), exp_vec(e));
            step();
        end
        enable = 1'b0;
        step();
        scl_in = 1'b1;
        check_val("abort_idle", dut_vec(), 32'd0);
        step();
        check_val("abort_idle2", dut_vec(), 32'd0);
        enable = 1'b1;
        #1;
        check_val("abort_ready", dut_vec(), 32'h80);
        owned = 1'b0;
        step();
    endtask

    // Asynchronous reset k cycles into a BIT.
    task automatic reset_test(input int unsigned k);
        cmd_valid   = 1'b1;
        cmd         = CMD_BIT;
        half_period = 10'd3;
        scl_in      = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (k) step();
        #1;
        n_rst = 1'b0;
        #1;
        check_val("arst_outputs", dut_vec(), 32'h80);
        @(negedge clk);
        n_rst  = 1'b1;
        scl_in = 1'b1;
        owned  = 1'b0;
        step();
        check_val("arst_idle", dut_vec(), 32'h80);
    endtask

    initial begin
        n_rst       = 1'b0;
        enable      = 1'b1;
        half_period = 10'd4;
        cmd_valid   = 1'b0;
        cmd         = CMD_START;
        scl_in      = 1'b1;
        #1;
        check_val("reset_async", dut_vec(), 32'h80);
        step();
        step();
        @(negedge clk);
        n_rst = 1'b1;
        step();
        check_val("reset_state", dut_vec(), 32'h80);

        run_cmd(CMD_START, 10'd4, 0);
        run_cmd(CMD_BIT,   10'd4, 0);
        run_cmd(CMD_BIT,   10'd4, 20);
        run_cmd(CMD_STOP,  10'd3, 0);
        run_cmd(CMD_BIT,   10'd4, 0);
        run_cmd(CMD_STOP,  10'd4, 0);
        run_cmd(CMD_START, 10'd2, 0);
        run_cmd(CMD_START, 10'd4, 2);
        run_cmd(CMD_BIT,   10'd0, 0);
        run_cmd(CMD_BIT,   10'd1, 1);
        run_cmd(CMD_RSVD,  10'd4, 0);
        abort_test(10'd4, 2);
        run_cmd(CMD_START, 10'd3, 0);
        reset_test(2);

        for (int n = 0; n < 120; n++) begin
            int unsigned r;
            int unsigned s;
            scl_cmd_t    c;
            r = $urandom_range(0, 19);
            s = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            if (owned && r == 0) begin
                abort_test(10'($urandom_range(2, 6)), 1);
            end else if (owned && r == 1) begin
                reset_test($urandom_range(0, 5));
            end else begin
                if (!owned && $urandom_range(0, 3) != 0) c = CMD_START;
                else c = scl_cmd_t'($urandom_range(0, 3));
                run_cmd(c, 10'($urandom_range(0, 7)), s);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
